sum_serialiser: RTL and testbench

SUM_SERIALISER -- requirements
Module: sum_serialiser

---
 rtl/sum_serialiser_pkg.sv | 25 ++
 rtl/sum_serialiser_if.sv | 21 ++
 rtl/sum_serialiser_bit_timer.sv | 38 +++
 rtl/sum_serialiser.sv | 142 ++++++++++++++
 tb/tb_sum_serialiser.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_serialiser_pkg.sv
// Shared types and constants for the sum serialiser.
// SUM_SERIALISER_PARITY_EN adds an even-parity bit to every frame.
package sum_serialiser_pkg;

`ifdef SUM_SERIALISER_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Wide enough for BIT_CYCLES up to 255.
  localparam int unsigned BitCntW = 8;

  function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef SUM_SERIALISER_PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction

endpackage

// File: rtl/sum_serialiser_if.sv
// Parallel-in handshake and serial-out status bundle of the sum serialiser.
interface sum_serialiser_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_tx, o_busy, o_done
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/sum_serialiser_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle
// of each serial bit.
module sum_serialiser_bit_timer
  import sum_serialiser_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam logic [BitCntW-1:0] LastCnt = BitCntW'(BIT_CYCLES - 1);

  logic [BitCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + BitCntW'(1);
    end
  end

  assign bit_end_o = en_i && !clear_i && (cnt_q == LastCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sum_serialiser.sv
// Serialises parallel sums into start/data/[parity]/stop frames, LSB first, with a
// one-entry holding register. SUM_SERIALISER_PARITY_EN enables the even-parity bit.
module sum_serialiser
  import sum_serialiser_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sum_serialiser_if.slave bus
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  state_e              state_d, state_q;
  logic                hold_full_d, hold_full_q;
  logic [DATA_W-1:0]   hold_data_d, hold_data_q;
  logic [DATA_W-1:0]   shift_d, shift_q;
  logic [IdxW-1:0]     idx_d, idx_q;
  logic                load_d, load_q;
`ifdef SUM_SERIALISER_PARITY_EN
  logic                parity_d, parity_q;
`endif
  logic                bit_end;
  logic                accept;
  logic                busy;

  assign accept = bus.i_valid && !hold_full_q;
  assign busy   = (state_q != StIdle);

  sum_serialiser_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .clear_i  (!busy),
    .en_i     (busy),
    .bit_end_o(bit_end)
  );

  // A word accepted this very cycle counts as "held" so the start bit follows at once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hold_full_q || accept) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && (idx_q == LastIdx)) begin
`ifdef SUM_SERIALISER_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef SUM_SERIALISER_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) state_d = (hold_full_q || accept) ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The held word moves to the shifter during the first start-bit cycle; the start bit
  // itself does not depend on the shifter, so this costs no latency.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    load_d      = (state_d == StStart) && (state_q != StStart);
`ifdef SUM_SERIALISER_PARITY_EN
    parity_d    = parity_q;
`endif
    if (load_q) begin
      shift_d     = hold_data_q;
      hold_full_d = 1'b0;
`ifdef SUM_SERIALISER_PARITY_EN
      parity_d    = ^hold_data_q;
`endif
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.i_data;
    end
    if ((state_q == StData) && bit_end) begin
      shift_d = shift_q >> 1;
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_comb begin
    bus.o_tx = STOP_BIT;
    case (state_q)
      StStart:  bus.o_tx = START_BIT;
      StData:   bus.o_tx = shift_q[0];
`ifdef SUM_SERIALISER_PARITY_EN
      StParity: bus.o_tx = parity_q;
`endif
      default:  bus.o_tx = STOP_BIT;
    endcase
  end

  assign bus.o_ready = !hold_full_q;
  assign bus.o_busy  = busy;
  assign bus.o_done  = (state_q == StStop) && bit_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      load_q      <= 1'b0;
`ifdef SUM_SERIALISER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      load_q      <= load_d;
`ifdef SUM_SERIALISER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_sum_serialiser.sv
// Bench for sum_serialiser: frame tables, directed corner sequences and random traffic
// checked cycle by cycle against a frame-timeline reference model.
module tb_sum_serialiser;

  localparam int DW   = 8;
  localparam int MAXC = 4096;
`ifdef SUM_SERIALISER_PARITY_EN
  localparam int FB   = DW + 3;
  localparam bit PAR  = 1'b1;
`else
  localparam int FB   = DW + 2;
  localparam bit PAR  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_serialiser_if #(.DATA_W(DW)) bus_a ();
  sum_serialiser_if #(.DATA_W(DW)) bus_b ();

  sum_serialiser #(.DATA_W(DW), .BIT_CYCLES(1)) dut_a (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_a)
  );

  sum_serialiser #(.DATA_W(DW), .BIT_CYCLES(4)) dut_b (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_b)
  );

  // Expected outputs of dut_a, indexed by absolute cycle number.
  logic exp_tx    [MAXC];
  logic exp_busy  [MAXC];
  logic exp_done  [MAXC];
  logic exp_ready [MAXC];
  int   cyc;
  int   line_free;
  bit   check_en;
  int   n_pass;
  int   n_checks;

  typedef struct {
    logic [7:0]  word;
    logic [0:11] frame;
    int          done_at;
  } vec_t;

  vec_t vecs [6];

  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (PAR && (k == DW + 1)) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Frame starts one cycle after acceptance or right after the previous frame ends.
  task automatic model_accept(input int n, input logic [DW-1:0] w);
    int st;
    st = (n + 1 > line_free) ? n + 1 : line_free;
    for (int k = 0; k < FB; k++) begin
      if (st + k < MAXC) begin
        exp_tx[st+k]   = frame_bit(w, k);
        exp_busy[st+k] = 1'b1;
        exp_done[st+k] = (k == FB - 1);
      end
    end
    for (int c = n + 1; c <= st; c++) begin
      if (c < MAXC) exp_ready[c] = 1'b0;
    end
    line_free = st + FB;
  endtask

  task automatic model_reset(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      exp_tx[c]    = 1'b1;
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_ready[c] = 1'b1;
    end
    line_free = r + 1;
  endtask

  task automatic tick();
    if (cyc >= MAXC - 64) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 64);
      $fatal(1, "cycle budget exceeded");
    end
    if (check_en) begin
      chk("model_tx",    32'(bus_a.o_tx),    32'(exp_tx[cyc]));
      chk("model_busy",  32'(bus_a.o_busy),  32'(exp_busy[cyc]));
      chk("model_done",  32'(bus_a.o_done),  32'(exp_done[cyc]));
      chk("model_ready", 32'(bus_a.o_ready), 32'(exp_ready[cyc]));
    end
    if (rst) model_reset(cyc);
    else if (bus_a.i_valid && exp_ready[cyc]) model_accept(cyc, bus_a.i_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:11] got;
    int          done_k;
    int          done_cnt;
    int          tx_low;
    logic        busy_after;

`ifdef SUM_SERIALISER_PARITY_EN
    vecs[0] = '{8'hA5, 12'b0_10100101_0_1_1, 10};
    vecs[1] = '{8'h07, 12'b0_11100000_1_1_1, 10};
    vecs[2] = '{8'h00, 12'b0_00000000_0_1_1, 10};
    vecs[3] = '{8'hFF, 12'b0_11111111_0_1_1, 10};
    vecs[4] = '{8'h80, 12'b0_00000001_1_1_1, 10};
    vecs[5] = '{8'h3C, 12'b0_00111100_0_1_1, 10};
`else
    vecs[0] = '{8'hA5, 12'b0_10100101_1_11, 9};
    vecs[1] = '{8'h07, 12'b0_11100000_1_11, 9};
    vecs[2] = '{8'h00, 12'b0_00000000_1_11, 9};
    vecs[3] = '{8'hFF, 12'b0_11111111_1_11, 9};
    vecs[4] = '{8'h80, 12'b0_00000001_1_11, 9};
    vecs[5] = '{8'h3C, 12'b0_00111100_1_11, 9};
`endif

    n_pass = 0;
    n_checks = 0;
    cyc = 0;
    line_free = 0;
    check_en = 1'b0;
    model_reset(-1);
    rst = 1'b1;
    bus_a.i_valid = 1'b0;
    bus_a.i_data  = '0;
    bus_b.i_valid = 1'b0;
    bus_b.i_data  = '0;

    tick();
    check_en = 1'b1;
    chk("reset_tx",    32'(bus_a.o_tx),    32'd1);
    chk("reset_busy",  32'(bus_a.o_busy),  32'd0);
    chk("reset_done",  32'(bus_a.o_done),  32'd0);
    chk("reset_ready", 32'(bus_a.o_ready), 32'd1);
    chk("reset_b_tx",  32'(bus_b.o_tx),    32'd1);
    tick();
    rst = 1'b0;

    // Single-word frames from the table; i_data is scrambled while shifting.
    foreach (vecs[i]) begin
      repeat (2) tick();
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = vecs[i].word;
      tick();
      bus_a.i_valid = 1'b0;
      done_k = -1;
      busy_after = 1'b1;
      for (int k = 0; k < 12; k++) begin
        got[k] = bus_a.o_tx;
        if (bus_a.o_done) done_k = k;
        if (k == vecs[i].done_at + 1) busy_after = bus_a.o_busy;
        bus_a.i_data = 8'($urandom);
        tick();
      end
      chk("vec_frame", 32'(got), 32'(vecs[i].frame));
      chk("vec_done_cycle", 32'(done_k), 32'(vecs[i].done_at));
      chk("vec_busy_after", 32'(busy_after), 32'd0);
    end

    // Back-to-back: 0x01 then 0xFF with i_valid held high.
    repeat (2) tick();
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 8'h01;
    tick();
    bus_a.i_data  = 8'hFF;
    for (int k = 1; k <= 2 * FB + 1; k++) begin
      if (k == 3) bus_a.i_valid = 1'b0;
      chk("b2b_ready", 32'(bus_a.o_ready), 32'((k == 2) || (k > FB + 1)));
      chk("b2b_tx", 32'(bus_a.o_tx),
          32'((k <= FB) ? frame_bit(8'h01, k - 1) :
              (k <= 2 * FB) ? frame_bit(8'hFF, k - 1 - FB) : 1'b1));
      chk("b2b_busy", 32'(bus_a.o_busy), 32'(k <= 2 * FB));
      chk("b2b_done", 32'(bus_a.o_done), 32'((k == FB) || (k == 2 * FB)));
      tick();
    end

    // Reset during data bit 3 of 0x3C with 0x55 buffered.
    repeat (2) tick();
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 8'h3C;
    tick();
    bus_a.i_valid = 1'b0;
    tick();
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 8'h55;
    tick();
    bus_a.i_valid = 1'b0;
    repeat (2) tick();
    chk("rst_mid_bit3", 32'(bus_a.o_tx), 32'd1);
    chk("rst_mid_held", 32'(bus_a.o_ready), 32'd0);
    rst = 1'b1;
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 8'h99;
    tick();
    rst = 1'b0;
    bus_a.i_valid = 1'b0;
    chk("rst_after_tx",    32'(bus_a.o_tx),    32'd1);
    chk("rst_after_ready", 32'(bus_a.o_ready), 32'd1);
    chk("rst_after_busy",  32'(bus_a.o_busy),  32'd0);
    done_cnt = 0;
    tx_low = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.o_done) done_cnt++;
      if (!bus_a.o_tx) tx_low++;
      tick();
    end
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_no_tx",   32'(tx_low),   32'd0);

    // BIT_CYCLES=4 instance: 0x80, every bit held four cycles.
    chk("b_ready", 32'(bus_b.o_ready), 32'd1);
    bus_b.i_valid = 1'b1;
    bus_b.i_data  = 8'h80;
    tick();
    bus_b.i_valid = 1'b0;
    for (int k = 1; k <= 4 * FB + 1; k++) begin
      bus_b.i_data = 8'($urandom);
      chk("b_tx", 32'(bus_b.o_tx),
          32'((k <= 4 * FB) ? frame_bit(8'h80, (k - 1) / 4) : 1'b1));
      if (k >= 33 && k <= 36) chk("b_msb", 32'(bus_b.o_tx), 32'd1);
      chk("b_done", 32'(bus_b.o_done), 32'(k == 4 * FB));
      chk("b_busy", 32'(bus_b.o_busy), 32'(k <= 4 * FB));
      tick();
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      bus_a.i_valid = ($urandom_range(0, 9) < 4);
      bus_a.i_data  = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus_a.i_valid = 1'b0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
